// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one external adder between two requesters.
// Rev 1.0
`default_nettype none

module adder_arbiter #(
   parameter int ADDER_LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   output logic       req1_ready,
   output logic [7:0] add_a,
   output logic [7:0] add_b,
   input  logic [7:0] add_sum,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_sum,
   output logic       rsp_id,
   output logic       busy,
   output logic [7:0] txn_count
);

   localparam logic [3:0] LATENCY = ADDER_LATENCY[3:0];

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       last_grant;
   logic [3:0] cnt;

   // A lone valid requester always wins; on contention the one not granted last wins.
   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = req0_valid && (!req1_valid || last_grant);
            req1_ready = req1_valid && (!req0_valid || !last_grant);
            if (req0_ready || req1_ready)
               state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt == 4'd0)
               state_nxt = RESP;
         end
         RESP: begin
            if (rsp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         add_a      <= 8'h00;
         add_b      <= 8'h00;
         rsp_valid  <= 1'b0;
         rsp_sum    <= 8'h00;
         rsp_id     <= 1'b0;
         txn_count  <= 8'h00;
         cnt        <= 4'd0;
         last_grant <= 1'b1;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (req0_ready) begin
                  add_a      <= req0_a;
                  add_b      <= req0_b;
                  rsp_id     <= 1'b0;
                  last_grant <= 1'b0;
                  cnt        <= LATENCY;
               end else if (req1_ready) begin
                  add_a      <= req1_a;
                  add_b      <= req1_b;
                  rsp_id     <= 1'b1;
                  last_grant <= 1'b1;
                  cnt        <= LATENCY;
               end
            end
            WAIT: begin
               // The count hits zero exactly when the adder output for add_a/add_b is valid.
               if (cnt == 4'd0) begin
                  rsp_sum   <= add_sum;
                  rsp_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  txn_count <= txn_count + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed self-checking bench for adder_arbiter (latency 1 and 3 instances).
`default_nettype none

module tb_adder_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
   logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
   logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy;
   logic [7:0] add_a, add_b, add_sum, rsp_sum, txn_count;

   logic       v3 = 1'b0;
   logic [7:0] a3 = 8'h00, b3 = 8'h00;
   logic       r0rdy3, r1rdy3, rspv3, rspid3, busy3;
   logic [7:0] adda3, addb3, sum3, rsps3, cnt3;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_count = 8'h00;

   always #5 clk = ~clk;

   adder_arbiter #(.ADDER_LATENCY(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
      .busy(busy), .txn_count(txn_count)
   );

   adder_arbiter #(.ADDER_LATENCY(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v3), .req0_a(a3), .req0_b(b3), .req0_ready(r0rdy3),
      .req1_valid(1'b0), .req1_a(8'h00), .req1_b(8'h00), .req1_ready(r1rdy3),
      .add_a(adda3), .add_b(addb3), .add_sum(sum3),
      .rsp_valid(rspv3), .rsp_ready(1'b1), .rsp_sum(rsps3), .rsp_id(rspid3),
      .busy(busy3), .txn_count(cnt3)
   );

   // External adder models: pipelines whose depth equals each instance's latency.
   logic [7:0] pipe1;
   logic [7:0] pipe3 [3];
   always @(posedge clk) begin
      pipe1    <= add_a + add_b;
      pipe3[0] <= adda3 + addb3;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign add_sum = pipe1;
   assign sum3    = pipe3[2];

   typedef struct {
      logic       id;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_sum;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_count = 8'h00;
   endtask

   // One single-requester transaction on the latency-1 instance, called at a negedge.
   task automatic run_txn(input logic id, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_sum, input bit full);
      int n = 0;
      rsp_ready = 1'b1;
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
      #1;
      while (!(id ? req1_ready : req0_ready)) begin
         if (n >= 20) begin
            check("accept_timeout", 32'(n), 32'd0);
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
         end
         @(negedge clk); #1; n++;
      end
      if (full) check("other_ready_low", 32'(id ? req0_ready : req1_ready), 32'd0);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      if (full) begin
         check("add_a_reg", 32'(add_a), 32'(a));
         check("add_b_reg", 32'(add_b), 32'(b));
         check("busy_wait", 32'(busy), 32'd1);
      end
      n = 1;
      while (!rsp_valid && n < 40) begin
         @(negedge clk); n++;
      end
      if (full) check("rsp_latency", 32'(n), 32'd3);
      check("rsp_sum", 32'(rsp_sum), 32'(exp_sum));
      check("rsp_id", 32'(rsp_id), 32'(id));
      exp_count = exp_count + 8'd1;
      @(negedge clk);
      if (full) begin
         check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
         check("txn_count", 32'(txn_count), 32'(exp_count));
      end
   endtask

   vec_t vecs [6];

   initial begin
      int  n;
      bit  g;
      bit  seen;

      vecs[0] = '{id: 1'b0, a: 8'h12, b: 8'h34, exp_sum: 8'h46};
      vecs[1] = '{id: 1'b1, a: 8'hFF, b: 8'h01, exp_sum: 8'h00};
      vecs[2] = '{id: 1'b0, a: 8'h80, b: 8'h80, exp_sum: 8'h00};
      vecs[3] = '{id: 1'b1, a: 8'h7F, b: 8'h01, exp_sum: 8'h80};
      vecs[4] = '{id: 1'b0, a: 8'hA5, b: 8'h5A, exp_sum: 8'hFF};
      vecs[5] = '{id: 1'b1, a: 8'h00, b: 8'h00, exp_sum: 8'h00};

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rst_add_a", 32'(add_a), 32'h00);
      check("rst_add_b", 32'(add_b), 32'h00);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_sum", 32'(rsp_sum), 32'h00);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_txn_count", 32'(txn_count), 32'h00);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_readys", 32'({req0_ready, req1_ready}), 32'd0);

      // Continuous contention from reset: grants alternate starting with requester 0.
      req0_a = 8'h10; req0_b = 8'h01; req1_a = 8'h20; req1_b = 8'h02;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         #1;
         while (!(req0_ready || req1_ready) && n < 20) begin
            @(negedge clk); #1; n++;
         end
         check("rr_single_grant", 32'(req0_ready & req1_ready), 32'd0);
         g = req1_ready;
         check("rr_grant", 32'(g), 32'(i % 2));
         @(negedge clk);
         n = 1;
         while (!rsp_valid && n < 40) begin
            @(negedge clk); n++;
         end
         check("rr_rsp_id", 32'(rsp_id), 32'(g));
         check("rr_rsp_sum", 32'(rsp_sum), g ? 32'h22 : 32'h11);
         #1;
         check("rr_no_accept_in_handshake", 32'({req0_ready, req1_ready}), 32'd0);
         exp_count = exp_count + 8'd1;
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("rr_txn_count", 32'(txn_count), 32'(exp_count));

      foreach (vecs[i]) run_txn(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_sum, 1'b1);

      // Response back-pressure: outputs frozen, no accepts while stalled.
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h06;
      #1;
      check("stall_accept", 32'(req0_ready), 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 8'h30; req1_b = 8'h03;
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk); n++;
      end
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         check("stall_rsp_sum", 32'(rsp_sum), 32'h0B);
         check("stall_rsp_id", 32'(rsp_id), 32'd0);
         check("stall_readys", 32'({req0_ready, req1_ready}), 32'd0);
         check("stall_busy", 32'(busy), 32'd1);
         check("stall_count", 32'(txn_count), 32'(exp_count));
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      check("handshake_no_accept", 32'(req1_ready), 32'd0);
      exp_count = exp_count + 8'd1;
      @(negedge clk);
      #1;
      check("stall_complete_count", 32'(txn_count), 32'(exp_count));
      check("stall_complete_valid", 32'(rsp_valid), 32'd0);
      check("next_idle_accept", 32'(req1_ready), 32'd1);
      run_txn(1'b1, 8'h30, 8'h03, 8'h33, 1'b0);

      // Reset while a transaction from requester 0 is waiting on the adder.
      req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
      n = 0;
      #1;
      while (!req0_ready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      @(negedge clk);
      req0_valid = 1'b0;
      check("pre_reset_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_count = 8'h00;
      check("wrst_add_a", 32'(add_a), 32'h00);
      check("wrst_add_b", 32'(add_b), 32'h00);
      check("wrst_rsp_sum", 32'(rsp_sum), 32'h00);
      check("wrst_rsp_id", 32'(rsp_id), 32'd0);
      check("wrst_busy", 32'(busy), 32'd0);
      check("wrst_count", 32'(txn_count), 32'h00);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid) seen = 1'b1;
         @(negedge clk);
      end
      check("wrst_no_response", 32'(seen), 32'd0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("wrst_grant0", 32'({req0_ready, req1_ready}), 32'b10);
      req0_valid = 1'b0; req1_valid = 1'b0;
      run_txn(1'b0, 8'h01, 8'h02, 8'h03, 1'b1);

      // Counter wrap.
      do_reset();
      for (int i = 0; i < 255; i++) run_txn(1'b0, 8'(i), 8'h01, 8'(i + 1), 1'b0);
      check("count_ff", 32'(txn_count), 32'hFF);
      run_txn(1'b1, 8'h02, 8'h02, 8'h04, 1'b0);
      check("count_wrap", 32'(txn_count), 32'h00);

      // Latency-3 instance: response first valid five cycles after the transfer.
      v3 = 1'b1; a3 = 8'h12; b3 = 8'h34;
      n = 0;
      #1;
      while (!r0rdy3 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      @(negedge clk);
      v3 = 1'b0;
      n = 1;
      while (!rspv3 && n < 40) begin
         @(negedge clk); n++;
      end
      check("lat3_latency", 32'(n), 32'd5);
      check("lat3_sum", 32'(rsps3), 32'h46);
      check("lat3_id", 32'(rspid3), 32'd0);
      @(negedge clk);
      check("lat3_count", 32'(cnt3), 32'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
